// File: rtl/sobel_pkg.sv
// Shared pixel/window definitions for sobel_window_gen and sobelBlock.
package sobel_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned WIN_PIX = 9;
  localparam int unsigned WIN_W   = PIX_W * WIN_PIX;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [WIN_W-1:0] window_t;

  // Byte index of a window element; row 0 is top, col 0 is left.
  function automatic int unsigned win_idx(input int unsigned row, input int unsigned col);
    return row * 3 + col;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-row delay line: dout is the sample written DEPTH shifts earlier.
module sobel_line_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  // Read-before-write at the same slot gives an exact DEPTH-shift delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (shift_en) mem[ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (shift_en) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to interior 3x3 windows for sobelBlock.
// Optional SOBEL_WIN_STATS_EN adds a per-frame accepted-window counter.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIN_W-1:0] window_data,
  output logic             window_valid,
  input  logic             window_ready,
  output logic             frame_done
`ifdef SOBEL_WIN_STATS_EN
  ,
  output logic [19:0]      win_count
`endif
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               accept, emit, col_last, row_last;
  pixel_t             lb0_dout, lb1_dout;
  window_t            win_q, win_nxt;
  logic [3*PIX_W-1:0] new_col;

  assign in_ready = !window_valid || window_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row == ROW_W'(IMG_HEIGHT - 1));
  assign emit     = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign new_col  = {in_pixel, lb0_dout, lb1_dout};

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb0 (
    .clk(clk), .rst(rst), .shift_en(accept), .din(in_pixel), .dout(lb0_dout)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
    .clk(clk), .rst(rst), .shift_en(accept), .din(lb0_dout), .dout(lb1_dout)
  );

  // Window after this accept: shift each row left, new right column enters.
  always_comb begin
    win_nxt = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        if (c < 2)
          win_nxt[win_idx(r, c)*PIX_W +: PIX_W] = win_q[win_idx(r, c + 1)*PIX_W +: PIX_W];
        else
          win_nxt[win_idx(r, c)*PIX_W +: PIX_W] = new_col[r*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      win_q        <= '0;
      window_valid <= 1'b0;
      window_data  <= '0;
      frame_done   <= 1'b0;
    end else if (clear) begin
      col          <= '0;
      row          <= '0;
      win_q        <= '0;
      window_valid <= 1'b0;
      window_data  <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= accept && row_last && col_last;
      if (accept) begin
        win_q <= win_nxt;
        col   <= col_last ? '0 : col + COL_W'(1);
        if (col_last) row <= row_last ? '0 : row + ROW_W'(1);
      end
      // Reload without a bubble when a new window arrives during a handshake.
      if (accept && emit) begin
        window_valid <= 1'b1;
        window_data  <= win_nxt;
      end else if (window_ready) begin
        window_valid <= 1'b0;
      end
    end
  end

`ifdef SOBEL_WIN_STATS_EN
  logic win_first;

  // Count restarts on the handshake of the frame's first window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_first <= 1'b0;
      win_count <= '0;
    end else if (clear) begin
      win_first <= 1'b0;
      win_count <= '0;
    end else begin
      if (window_valid && window_ready)
        win_count <= win_first ? 20'd1 : win_count + 20'd1;
      if (accept && emit)
        win_first <= (row == ROW_W'(2)) && (col == COL_W'(2));
    end
  end
`endif

endmodule
